gelato_l2_cache_responder: RTL

Slave end of gelato_l2_cache_if: accepts line requests from the L1 cache and returns one full l1_cache_line_t per request. It holds a small direct-mapped, read-only L2 line store, each line the same size as an L1 line. On a hit it answers from the store. On a miss it refills the line from backing memory over a word-serial port, writes it into the store, then answers. It sits between the L1 caches and the memory controller.

---
 rtl/gelato_l2_cache_responder_pkg.sv | 30 +++
 rtl/gelato_l2_cache_if.sv | 17 +
 rtl/gelato_l2_line_store.sv | 73 +++++++
 rtl/gelato_l2_cache_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gelato_l2_cache_responder_pkg.sv
// gelato_types
//   Shared types for the gelato cache hierarchy.
//   - addr_t / l1_cache_line_t : byte address and one full L1 line
//   - L2_WORD_WIDTH            : width of one refill beat from memory
//   - L1_LINE_OFFSET_BITS      : byte-offset bits inside a line
//   - l2_state_e               : L2 responder controller states
//   - satInc                   : saturating increment for 32-bit counters
package gelato_types;

    typedef logic [31:0]  addr_t;
    typedef logic [255:0] l1_cache_line_t;

    localparam int L2_WORD_WIDTH       = 32;
    localparam int L1_LINE_OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP
    } l2_state_e;

    // Counters stop at all-ones instead of wrapping, so a long-running
    // system never reports a tiny count after overflow.
    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/gelato_l2_cache_if.sv
// gelato_l2_cache_if
//   Request/response channel between an L1 cache (master) and the L2
//   responder (slave).
//   - valid/addr : request from the L1, held stable until done
//   - done/data  : one-cycle completion pulse with the full line
interface gelato_l2_cache_if;
    import gelato_types::*;

    logic           valid;
    addr_t          addr;
    logic           done;
    l1_cache_line_t data;

    modport master (output valid, output addr, input done, input data);
    modport slave  (input valid, input addr, output done, output data);

endinterface

// File: rtl/gelato_l2_line_store.sv
// gelato_l2_line_store
//   Direct-mapped tag/data/valid array with one synchronous read port
//   and one write port.
//   - clk, rst_n              : clock and synchronous active-low reset
//   - rdEn_i, rdIndex_i       : read request; results appear next cycle
//   - rdValid_o, rdTag_o,
//     rdData_o                : registered read results
//   - wrEn_i, wrIndex_i,
//     wrTag_i, wrData_i       : write one whole line and mark it valid
//   Only the valid bits are cleared by reset; tags and data come up
//   undefined and are never trusted until their valid bit is set.
module gelato_l2_line_store
    import gelato_types::*;
#(
    parameter int NUM_SETS    = 64,
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 21
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rdEn_i,
    input  logic [INDEX_WIDTH-1:0] rdIndex_i,
    output logic                   rdValid_o,
    output logic [TAG_WIDTH-1:0]   rdTag_o,
    output l1_cache_line_t         rdData_o,
    input  logic                   wrEn_i,
    input  logic [INDEX_WIDTH-1:0] wrIndex_i,
    input  logic [TAG_WIDTH-1:0]   wrTag_i,
    input  l1_cache_line_t         wrData_i
);

    logic [NUM_SETS-1:0]  lineValid_q;
    logic [TAG_WIDTH-1:0] tagMem [NUM_SETS];
    l1_cache_line_t       dataMem [NUM_SETS];

    logic                 rdValid_q;
    logic [TAG_WIDTH-1:0] rdTag_q;
    l1_cache_line_t       rdData_q;

    // Valid bits and the registered valid read-out: these are the only
    // state that must be cleared, so that every line misses after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lineValid_q <= '0;
            rdValid_q   <= 1'b0;
        end else begin
            if (wrEn_i) begin
                lineValid_q[wrIndex_i] <= 1'b1;
            end
            if (rdEn_i) begin
                rdValid_q <= lineValid_q[rdIndex_i];
            end
        end
    end

    // Tag and data storage with registered read; no reset so these map
    // onto plain RAM.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            tagMem[wrIndex_i]  <= wrTag_i;
            dataMem[wrIndex_i] <= wrData_i;
        end
        if (rdEn_i) begin
            rdTag_q  <= tagMem[rdIndex_i];
            rdData_q <= dataMem[rdIndex_i];
        end
    end

    assign rdValid_o = rdValid_q;
    assign rdTag_o   = rdTag_q;
    assign rdData_o  = rdData_q;

endmodule

// File: rtl/gelato_l2_cache_responder.sv
// gelato_l2_cache_responder
//   Read-only direct-mapped L2 that answers L1 line requests. Hits are
//   served from the line store; misses fetch the line word-serially from
//   backing memory, install it, then answer.
//   - clk, rst_n     : clock and synchronous active-low reset
//   - l1_if          : slave side of the L1 request channel
//   - mem_req_valid,
//     mem_req_ready,
//     mem_req_addr   : line fetch request to memory (line-aligned)
//   - mem_resp_valid,
//     mem_resp_data  : refill beats, word 0 first
//   - perf_hits,
//     perf_misses    : saturating lookup counters
module gelato_l2_cache_responder
    import gelato_types::*;
#(
    parameter int NUM_SETS       = 64,
    parameter int WORDS_PER_LINE = 8,
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    gelato_l2_cache_if.slave          l1_if,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [L2_WORD_WIDTH-1:0]  mem_resp_data,
    output logic [31:0]               perf_hits,
    output logic [31:0]               perf_misses
);

    localparam int ADDR_WIDTH      = $bits(addr_t);
    localparam int INDEX_WIDTH     = $clog2(NUM_SETS);
    localparam int LINE_ADDR_WIDTH = ADDR_WIDTH - L1_LINE_OFFSET_BITS;
    localparam int TAG_WIDTH       = LINE_ADDR_WIDTH - INDEX_WIDTH;
    localparam int BEAT_WIDTH      = $clog2(WORDS_PER_LINE);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(WORDS_PER_LINE - 1);

    l2_state_e                  state_q, state_d;
    logic [LINE_ADDR_WIDTH-1:0] lineAddr_q, lineAddr_d;
    logic                       memReqValid_q, memReqValid_d;
    logic [MEM_ADDR_WIDTH-1:0]  memReqAddr_q, memReqAddr_d;
    logic [BEAT_WIDTH-1:0]      beatCnt_q, beatCnt_d;
    l1_cache_line_t             lineBuf_q, lineBuf_d;
    l1_cache_line_t             respData_q, respData_d;
    logic [31:0]                hits_q, hits_d;
    logic [31:0]                misses_q, misses_d;

    logic [INDEX_WIDTH-1:0]     reqIndex;
    logic [INDEX_WIDTH-1:0]     curIndex;
    logic [TAG_WIDTH-1:0]       curTag;
    logic                       storeRdEn;
    logic                       storeWrEn;
    logic                       storeRdValid;
    logic [TAG_WIDTH-1:0]       storeRdTag;
    l1_cache_line_t             storeRdData;
    logic                       lookupHit;
    logic                       lastBeat;
    l1_cache_line_t             assembledLine;
    logic                       doneOut;
    logic                       unusedOffsetBits;

    // The byte offset inside the line never influences which line is
    // returned, so those request bits are deliberately dropped.
    assign unusedOffsetBits = ^l1_if.addr[L1_LINE_OFFSET_BITS-1:0];

    assign reqIndex  = l1_if.addr[L1_LINE_OFFSET_BITS +: INDEX_WIDTH];
    assign curIndex  = lineAddr_q[INDEX_WIDTH-1:0];
    assign curTag    = lineAddr_q[LINE_ADDR_WIDTH-1 -: TAG_WIDTH];
    assign lookupHit = storeRdValid && (storeRdTag == curTag);
    assign lastBeat  = (beatCnt_q == LAST_BEAT);

    gelato_l2_line_store #(
        .NUM_SETS    (NUM_SETS),
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_line_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdEn_i    (storeRdEn),
        .rdIndex_i (reqIndex),
        .rdValid_o (storeRdValid),
        .rdTag_o   (storeRdTag),
        .rdData_o  (storeRdData),
        .wrEn_i    (storeWrEn),
        .wrIndex_i (curIndex),
        .wrTag_i   (curTag),
        .wrData_i  (assembledLine)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. LOOKUP always lasts exactly one cycle because the
    // store read was launched on the IDLE->LOOKUP edge; RESP always lasts
    // one cycle so done is a single pulse and the master may start a new
    // request right after it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (l1_if.valid) state_d = LOOKUP;
            LOOKUP:   state_d = lookupHit ? RESP : MISS_REQ;
            MISS_REQ: if (mem_req_ready) state_d = REFILL;
            REFILL:   if (mem_resp_valid && lastBeat) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Line being refilled with the current beat merged in. On the last
    // beat this is the complete line, written to the store and returned
    // in the same cycle without waiting for lineBuf_q to catch up.
    always_comb begin
        assembledLine = lineBuf_q;
        assembledLine[int'(beatCnt_q)*L2_WORD_WIDTH +: L2_WORD_WIDTH] = mem_resp_data;
    end

    // Output and datapath next-state logic for every state. The store write
    // is gated by rst_n so a refill interrupted by reset never lands in the
    // array, even if its last beat coincides with the reset edge.
    always_comb begin
        lineAddr_d    = lineAddr_q;
        memReqValid_d = memReqValid_q;
        memReqAddr_d  = memReqAddr_q;
        beatCnt_d     = beatCnt_q;
        lineBuf_d     = lineBuf_q;
        respData_d    = respData_q;
        hits_d        = hits_q;
        misses_d      = misses_q;
        storeRdEn     = 1'b0;
        storeWrEn     = 1'b0;
        doneOut       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (l1_if.valid) begin
                    lineAddr_d = l1_if.addr[ADDR_WIDTH-1:L1_LINE_OFFSET_BITS];
                    storeRdEn  = 1'b1;
                end
            end
            LOOKUP: begin
                if (lookupHit) begin
                    respData_d = storeRdData;
                    hits_d     = satInc(hits_q);
                end else begin
                    misses_d      = satInc(misses_q);
                    memReqValid_d = 1'b1;
                    memReqAddr_d  = MEM_ADDR_WIDTH'({lineAddr_q, {L1_LINE_OFFSET_BITS{1'b0}}});
                end
            end
            MISS_REQ: begin
                if (mem_req_ready) begin
                    memReqValid_d = 1'b0;
                    beatCnt_d     = '0;
                end
            end
            REFILL: begin
                if (mem_resp_valid) begin
                    lineBuf_d = assembledLine;
                    beatCnt_d = beatCnt_q + BEAT_WIDTH'(1);
                    if (lastBeat) begin
                        storeWrEn  = rst_n;
                        respData_d = assembledLine;
                    end
                end
            end
            RESP: begin
                doneOut = 1'b1;
            end
            default: begin
                doneOut = 1'b0;
            end
        endcase
    end

    // Datapath registers. Everything visible at the ports returns to zero
    // on reset so a reset in the middle of a refill leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lineAddr_q    <= '0;
            memReqValid_q <= 1'b0;
            memReqAddr_q  <= '0;
            beatCnt_q     <= '0;
            lineBuf_q     <= '0;
            respData_q    <= '0;
            hits_q        <= '0;
            misses_q      <= '0;
        end else begin
            lineAddr_q    <= lineAddr_d;
            memReqValid_q <= memReqValid_d;
            memReqAddr_q  <= memReqAddr_d;
            beatCnt_q     <= beatCnt_d;
            lineBuf_q     <= lineBuf_d;
            respData_q    <= respData_d;
            hits_q        <= hits_d;
            misses_q      <= misses_d;
        end
    end

    assign l1_if.done    = doneOut;
    assign l1_if.data    = respData_q;
    assign mem_req_valid = memReqValid_q;
    assign mem_req_addr  = memReqAddr_q;
    assign perf_hits     = hits_q;
    assign perf_misses   = misses_q;

endmodule
